piccolo80: RTL and testbench
============================

# piccolo80

Round-iterative Piccolo-80 block-cipher encryption core: 64-bit plaintext, 80-bit key, 25 rounds, one round per clock. It runs one encryption after each reset release and holds the ciphertext until the next reset. It is a standalone crypto datapath; the key is a build-time constant unless the key-port option is compiled in.

## Interface
- No parameters.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `plaintext` input 64 ([0:63], bit 0 = MSB): block to encrypt. Must be stable from reset release until `done`.
- `keyin` input 80 ([0:79]): present only with `PICCOLO_KEYIN_EN`. Must be stable from reset release until `done`.
- `ciphertext` output 64 ([0:63]): registered result.
- `done` output 1: high once `ciphertext` is valid. Sticky until reset.

## Operation
- Block: X = X0|X1|X2|X3, 16-bit words, X0 = MSB.
- Key: K = k0|k1|k2|k3|k4, 16-bit words. kL/kR = upper/lower byte of a word.
- Whitening keys:
  - wk0 = kL0|kR1, wk1 = kL1|kR0
  - wk2 = kL4|kR3, wk3 = kL3|kR4
- Round keys, i = 0..24: (rk2i|rk2i+1) = con_i ^ Ksel(i mod 5).
  - Ksel(0) = Ksel(2) = k2|k3
  - Ksel(1) = Ksel(4) = k0|k1
  - Ksel(3) = k4|k4
- Constant: con_i = (c|00000|c|00|c|00000|c) ^ 32'h0f1e2d3c, with c = 5-bit (i+1). Generate on the fly from the round counter.
- F(16b) = S(M(S(x))).
  - S is the nibble S-box e,4,b,2,3,8,0,9,1,a,7,f,6,c,5,d (index 0..f), applied to all 4 nibbles.
  - M is the 4×4 matrix over GF(2^4), polynomial x^4+x+1, rows [2 3 1 1],[1 2 3 1],[1 1 2 3],[3 1 1 2]. Nibble 0 = MSB.
- Round i:
  - X1 ^= F(X0) ^ rk2i
  - X3 ^= F(X2) ^ rk2i+1
  - For i < 24, then apply RP: bytes (b0..b7) → (b2,b7,b4,b1,b6,b3,b0,b5).
  - Round 24 omits RP.
- Whitening:
  - Before round 0: X0 ^= wk0, X2 ^= wk1.
  - After round 24: X0 ^= wk2, X2 ^= wk3.
- FSM:
  - RUN: counter 0..24. At counter 0 the round input is whitened `plaintext`; otherwise it is the state register.
  - DONE: reached after round 24. State and counter frozen, inputs ignored.
  - Only `reset` leaves DONE.

## Timing
- During reset: state = 0, counter = 0, `ciphertext` = 64'h0, `done` = 0, FSM = RUN.
- Edge n (n = 1..25) after reset deasserts executes round n−1.
- Edge 25: `ciphertext` gets the final whitened result and `done` rises, both registered. Latency is 25 cycles.
- `ciphertext` stays 0 before edge 25 and is never a partial state.
- Reset asserted mid-encryption aborts at once, clears all outputs, and restarts from round 0 on release.
- `plaintext` or key changes after edge 1 have no effect. Only the edge-1 sample is used.

## Configuration
- `PICCOLO_KEYIN_EN` defined: the `keyin` port exists and all key material comes from it.
- Undefined: no `keyin` port; key hardwired to 80'h00112233445566778899.
- Datapath and timing are identical in both builds.

## Test plan
- Default build, reset low 10 ns then high, `plaintext` = 64'h0123456789abcdef → `done` rises at edge 25, `ciphertext` = 64'h8d2bff9935f84056; `ciphertext` = 0 and `done` = 0 at edges 1..24.
- Hold 200 cycles after `done` and toggle `plaintext` → `ciphertext` and `done` unchanged.
- Pulse reset low at edge 12, then release → outputs clear asynchronously; ciphertext 8d2bff9935f84056 appears 25 edges after release.
- `PICCOLO_KEYIN_EN` build, `keyin` = 80'h00112233445566778899, same `plaintext` → 8d2bff9935f84056; then `keyin` = 0, `plaintext` = 0 → matches the golden software model.
- Unit-check F and RP against the golden model:
  - S-box: S(0) = e, S(f) = d.
  - RP: 64'h0011223344556677 → 64'h2277441166330055.

Source files
------------

// File: rtl/piccolo80.sv
// Piccolo-80 encryption core: one round per clock, 25 rounds, result held until reset.
// Define PICCOLO_KEYIN_EN to take the key from the keyin port instead of the built-in constant.
module piccolo80 (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:63] plaintext,
`ifdef PICCOLO_KEYIN_EN
    input  logic [0:79] keyin,
`endif
    output logic [0:63] ciphertext,
    output logic        done
);

    typedef enum logic {ST_RUN, ST_DONE} fsm_t;

    fsm_t        fsm;
    logic [4:0]  cnt;
    logic [63:0] state;
    logic [63:0] pt;
    logic [79:0] key;

    assign pt = plaintext;

`ifdef PICCOLO_KEYIN_EN
    logic [79:0] key_q;

    // Round 0 uses the port directly; later rounds use the key captured on that same edge.
    assign key = (cnt == 5'd0) ? keyin : key_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            key_q <= '0;
        else if (fsm == ST_RUN && cnt == 5'd0)
            key_q <= keyin;
    end
`else
    localparam logic [79:0] KEY = 80'h00112233445566778899;
    assign key = KEY;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'he;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hb;  4'h3: sbox = 4'h2;
            4'h4: sbox = 4'h3;  4'h5: sbox = 4'h8;  4'h6: sbox = 4'h0;  4'h7: sbox = 4'h9;
            4'h8: sbox = 4'h1;  4'h9: sbox = 4'ha;  4'ha: sbox = 4'h7;  4'hb: sbox = 4'hf;
            4'hc: sbox = 4'h6;  4'hd: sbox = 4'hc;  4'he: sbox = 4'h5;  default: sbox = 4'hd;
        endcase
    endfunction

    // Multiply by x in GF(2^4) with x^4 = x + 1.
    function automatic logic [3:0] mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] mix(input logic [15:0] x);
        logic [3:0] n0, n1, n2, n3;
        {n0, n1, n2, n3} = x;
        return {mul2(n0) ^ mul2(n1) ^ n1 ^ n2 ^ n3,
                n0 ^ mul2(n1) ^ mul2(n2) ^ n2 ^ n3,
                n0 ^ n1 ^ mul2(n2) ^ mul2(n3) ^ n3,
                mul2(n0) ^ n0 ^ n1 ^ n2 ^ mul2(n3)};
    endfunction

    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [15:0] s;
        s = mix({sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])});
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    // Byte permutation (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5).
    function automatic logic [63:0] rp(input logic [63:0] x);
        return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
    endfunction

    logic [15:0] k0, k1, k2, k3, k4;
    logic [15:0] wk0, wk1, wk2, wk3;
    logic [31:0] ksel, rk;
    logic [4:0]  c;
    logic [63:0] blk, next_state, final_out;
    logic [15:0] x1n, x3n;

    assign {k0, k1, k2, k3, k4} = key;
    assign wk0 = {k0[15:8], k1[7:0]};
    assign wk1 = {k1[15:8], k0[7:0]};
    assign wk2 = {k4[15:8], k3[7:0]};
    assign wk3 = {k3[15:8], k4[7:0]};

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ksel = {k2, k3};
        case (cnt % 5'd5)
            5'd1, 5'd4: ksel = {k0, k1};
            5'd3:       ksel = {k4, k4};
            default:    ksel = {k2, k3};
        endcase
        c   = cnt + 5'd1;
        rk  = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h0f1e2d3c ^ ksel;
        blk = (cnt == 5'd0) ? {pt[63:48] ^ wk0, pt[47:32], pt[31:16] ^ wk1, pt[15:0]} : state;
        x1n = blk[47:32] ^ f_fn(blk[63:48]) ^ rk[31:16];
        x3n = blk[15:0]  ^ f_fn(blk[31:16]) ^ rk[15:0];
        next_state = rp({blk[63:48], x1n, blk[31:16], x3n});
        final_out  = {blk[63:48] ^ wk2, x1n, blk[31:16] ^ wk3, x3n};
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm        <= ST_RUN;
            cnt        <= '0;
            state      <= '0;
            ciphertext <= '0;
            done       <= 1'b0;
        end else begin
            case (fsm)
                ST_RUN: begin
                    if (cnt == 5'd24) begin
                        ciphertext <= final_out;
                        done       <= 1'b1;
                        fsm        <= ST_DONE;
                    end else begin
                        state <= next_state;
                        cnt   <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piccolo80.sv
// Self-checking bench for piccolo80: vector table, expected-result queue, reset and hold sequences.
module tb_piccolo80;

    localparam logic [79:0] DEF_KEY = 80'h00112233445566778899;
    localparam logic [3:0]  SB [16] = '{4'he, 4'h4, 4'hb, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
                                        4'h1, 4'ha, 4'h7, 4'hf, 4'h6, 4'hc, 4'h5, 4'hd};
    localparam int MT [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    localparam int PERM [8] = '{2, 7, 4, 1, 6, 3, 0, 5};

    logic        clk;
    logic        reset;
    logic [63:0] plaintext;
    logic [63:0] ciphertext;
    logic        done;
`ifdef PICCOLO_KEYIN_EN
    logic [79:0] keyin;
`endif

    piccolo80 dut (
        .clk        (clk),
        .reset      (reset),
        .plaintext  (plaintext),
`ifdef PICCOLO_KEYIN_EN
        .keyin      (keyin),
`endif
        .ciphertext (ciphertext),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pt;
        logic [79:0] key;
        logic [63:0] exp;
        bit          scramble;
    } vec_t;

    vec_t        vecs [$];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model built from generic GF(2^4) arithmetic and table lookups.
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [15:0] m_f(input logic [15:0] x);
        logic [3:0]  n [4];
        logic [3:0]  y;
        logic [15:0] r;
        for (int j = 0; j < 4; j++) n[j] = SB[x[15-4*j -: 4]];
        r = '0;
        for (int rr = 0; rr < 4; rr++) begin
            y = '0;
            for (int cc = 0; cc < 4; cc++) y ^= gmul(4'(MT[rr][cc]), n[cc]);
            r[15-4*rr -: 4] = SB[y];
        end
        return r;
    endfunction

    function automatic logic [63:0] m_rp(input logic [63:0] x);
        logic [7:0]  b [8];
        logic [63:0] r;
        for (int j = 0; j < 8; j++) b[j] = x[63-8*j -: 8];
        for (int j = 0; j < 8; j++) r[63-8*j -: 8] = b[PERM[j]];
        return r;
    endfunction

    function automatic logic [63:0] m_encrypt(input logic [63:0] pt, input logic [79:0] key);
        logic [15:0] k [5];
        logic [15:0] x [4];
        logic [31:0] c, con, sel;
        logic [63:0] t;
        for (int j = 0; j < 5; j++) k[j] = key[79-16*j -: 16];
        for (int j = 0; j < 4; j++) x[j] = pt[63-16*j -: 16];
        x[0] ^= {k[0][15:8], k[1][7:0]};
        x[2] ^= {k[1][15:8], k[0][7:0]};
        for (int r = 0; r < 25; r++) begin
            c   = 32'(r + 1);
            con = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0f1e2d3c;
            case (r % 5)
                0, 2:    sel = {k[2], k[3]};
                1, 4:    sel = {k[0], k[1]};
                default: sel = {k[4], k[4]};
            endcase
            x[1] ^= m_f(x[0]) ^ con[31:16] ^ sel[31:16];
            x[3] ^= m_f(x[2]) ^ con[15:0]  ^ sel[15:0];
            if (r < 24) begin
                t = m_rp({x[0], x[1], x[2], x[3]});
                for (int j = 0; j < 4; j++) x[j] = t[63-16*j -: 16];
            end
        end
        x[0] ^= {k[4][15:8], k[3][7:0]};
        x[2] ^= {k[3][15:8], k[4][7:0]};
        return {x[0], x[1], x[2], x[3]};
    endfunction

    task automatic add_vec(input logic [63:0] pt, input logic [79:0] key,
                           input logic [63:0] exp, input bit scramble);
        vec_t v;
        v.pt = pt; v.key = key; v.exp = exp; v.scramble = scramble;
        vecs.push_back(v);
    endtask

    task automatic apply_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic run_one(input vec_t v, input string name);
        int          early_bad;
        logic [63:0] want;
        plaintext = v.pt;
`ifdef PICCOLO_KEYIN_EN
        keyin = v.key;
`endif
        exp_q.push_back(v.exp);
        apply_reset();
        early_bad = 0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk);
            #1;
            if (n == 1 && v.scramble) begin
                plaintext = ~v.pt;
`ifdef PICCOLO_KEYIN_EN
                keyin = ~v.key;
`endif
            end
            if (n < 25 && (done !== 1'b0 || ciphertext !== 64'h0)) early_bad++;
        end
        check({name, " early output"}, 64'(early_bad), 64'h0);
        check({name, " done at edge 25"}, 64'(done), 64'h1);
        if (exp_q.size() == 0) check({name, " scoreboard empty"}, 64'h1, 64'h0);
        else begin
            want = exp_q.pop_front();
            check({name, " ciphertext"}, ciphertext, want);
        end
    endtask

    initial begin
        int          bad;
        logic [63:0] r;
        reset     = 1'b0;
        plaintext = '0;
`ifdef PICCOLO_KEYIN_EN
        keyin = DEF_KEY;
`endif
        #3;
        check("reset ciphertext", ciphertext, 64'h0);
        check("reset done", 64'(done), 64'h0);

        add_vec(64'h0123456789abcdef, DEF_KEY, 64'h8d2bff9935f84056, 1'b0);
        add_vec(64'h0, DEF_KEY, m_encrypt(64'h0, DEF_KEY), 1'b1);
        add_vec('1, DEF_KEY, m_encrypt('1, DEF_KEY), 1'b0);
        for (int i = 0; i < 3; i++) begin
            r = {$urandom, $urandom};
            add_vec(r, DEF_KEY, m_encrypt(r, DEF_KEY), 1'b1);
        end
`ifdef PICCOLO_KEYIN_EN
        add_vec(64'h0, 80'h0, m_encrypt(64'h0, 80'h0), 1'b0);
        for (int i = 0; i < 2; i++) begin
            logic [79:0] kr;
            kr = {$urandom, $urandom, 16'($urandom)};
            r  = {$urandom, $urandom};
            add_vec(r, kr, m_encrypt(r, kr), 1'b1);
        end
`endif
        foreach (vecs[i]) run_one(vecs[i], $sformatf("vec%0d", i));

        // Hold with plaintext toggling: output must stay frozen.
        run_one(vecs[0], "hold setup");
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk) plaintext = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (ciphertext !== 64'h8d2bff9935f84056 || done !== 1'b1) bad++;
        end
        check("hold unstable cycles", 64'(bad), 64'h0);
        check("hold ciphertext", ciphertext, 64'h8d2bff9935f84056);

        // Asynchronous clear from the done state, mid-cycle.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async clear ciphertext", ciphertext, 64'h0);
        check("async clear done", 64'(done), 64'h0);

        // Abort at edge 12, then a full restart from round 0.
        plaintext = 64'h0123456789abcdef;
        @(negedge clk) reset = 1'b1;
        repeat (12) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort ciphertext", ciphertext, 64'h0);
        check("abort done", 64'(done), 64'h0);
        run_one(vecs[0], "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
